// File: rtl/demux1_n_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with packet-locked select.
// Optional statistics counters are enabled with `define DEMUX1N_STATS_EN.
module demux1_n_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  input  logic [SEL_W-1:0]      A,
  output logic [N_CH*WIDTH-1:0] Y,
  output logic [N_CH-1:0]       y_valid,
  output logic [N_CH-1:0]       y_last,
  input  logic [N_CH-1:0]       y_ready,
  output logic                  err
`ifdef DEMUX1N_STATS_EN
  ,
  output logic [15:0]           drop_cnt,
  output logic [N_CH*16-1:0]    beat_cnt
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam logic [SEL_W:0] NCH_W = (SEL_W+1)'(N_CH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] dest;
  logic             oor;
  logic             sel_busy;
  logic             accept;
  logic             load;

  // Destination decode; a held, undrained channel is the only thing that stalls the input
  always_comb begin
    dest     = (state == LOCKED) ? lock_sel : A;
    oor      = {1'b0, dest} >= NCH_W;
    sel_busy = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (dest == SEL_W'(i)) sel_busy = y_valid[i] & ~y_ready[i];
    end
    din_ready = oor | ~sel_busy;
    accept    = din_valid & din_ready;
    load      = accept & ~oor;
  end

  // One-deep channel registers; a load wins over a drain so back-to-back beats leave no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y       <= '0;
      y_valid <= '0;
      y_last  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load && dest == SEL_W'(i)) begin
          Y[i*WIDTH +: WIDTH] <= din;
          y_last[i]           <= din_last;
          y_valid[i]          <= 1'b1;
        end else if (y_ready[i]) begin
          y_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Packet lock: select is captured on the first beat and held until the last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
      err      <= 1'b0;
    end else begin
      err <= accept & oor;
      case (state)
        IDLE: begin
          if (accept && !din_last) begin
            state    <= LOCKED;
            lock_sel <= A;
          end
        end
        LOCKED: begin
          if (accept && din_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX1N_STATS_EN
  // Drop counter saturates; per-channel beat counters wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept && oor && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      for (int i = 0; i < N_CH; i++) begin
        if (y_valid[i] && y_ready[i])
          beat_cnt[i*CNT_W +: CNT_W] <= beat_cnt[i*CNT_W +: CNT_W] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1_n_stream.sv
// Bench for demux1_n_stream: a 4-channel instance with a per-channel scoreboard
// and a 3-channel instance for out-of-range select handling.
module tb_demux1_n_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic [7:0]  din;
  logic        din_valid, din_last, din_ready;
  logic [1:0]  a;
  logic [31:0] y;
  logic [3:0]  y_valid, y_last, y_ready;
  logic        err;

  // 3-channel instance
  logic [7:0]  din3;
  logic        v3, last3, rdy3;
  logic [1:0]  a3;
  logic [23:0] y3;
  logic [2:0]  yv3, yl3, yr3;
  logic        err3;

`ifdef DEMUX1N_STATS_EN
  logic [15:0] drop_cnt4, drop_cnt3;
  logic [63:0] beat_cnt4;
  logic [47:0] beat_cnt3;
`endif

  demux1_n_stream #(.WIDTH(8), .N_CH(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .A(a), .Y(y), .y_valid(y_valid), .y_last(y_last),
    .y_ready(y_ready), .err(err)
`ifdef DEMUX1N_STATS_EN
    , .drop_cnt(drop_cnt4), .beat_cnt(beat_cnt4)
`endif
  );

  demux1_n_stream #(.WIDTH(8), .N_CH(3)) u3 (
    .clk(clk), .rst(rst), .din(din3), .din_valid(v3), .din_last(last3),
    .din_ready(rdy3), .A(a3), .Y(y3), .y_valid(yv3), .y_last(yl3),
    .y_ready(yr3), .err(err3)
`ifdef DEMUX1N_STATS_EN
    , .drop_cnt(drop_cnt3), .beat_cnt(beat_cnt3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      sb[4][$];
  logic       m_locked;
  logic [1:0] m_sel;

  task automatic clear_model();
    for (int i = 0; i < 4; i++) sb[i].delete();
    m_locked = 1'b0;
    m_sel    = 2'd0;
  endtask

  // One clock on the 4-channel instance, checked against the scoreboard
  task automatic cyc();
    logic [1:0] dst;
    logic       exp_rdy, acc;
    logic [3:0] mv, drain;
    beat_t      b;
    for (int i = 0; i < 4; i++) begin
      mv[i]    = sb[i].size() != 0;
      drain[i] = mv[i] & y_ready[i];
      if (mv[i]) begin
        check($sformatf("y_data ch%0d", i), 64'(y[i*8 +: 8]), 64'(sb[i][0].d));
        check($sformatf("y_last ch%0d", i), 64'(y_last[i]), 64'(sb[i][0].l));
      end
    end
    dst     = m_locked ? m_sel : a;
    exp_rdy = ~mv[dst] | y_ready[dst];
    check("din_ready", 64'(din_ready), 64'(exp_rdy));
    acc = din_valid & exp_rdy;
    b.d = din;
    b.l = din_last;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (drain[i]) void'(sb[i].pop_front());
    if (acc) begin
      sb[dst].push_back(b);
      if (!m_locked && !b.l) begin
        m_locked = 1'b1;
        m_sel    = a;
      end else if (m_locked && b.l) begin
        m_locked = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) mv[i] = sb[i].size() != 0;
    check("y_valid", 64'(y_valid), 64'(mv));
    check("err", 64'(err), 64'(1'b0));
  endtask

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic       last;
    logic [3:0] rdy;
    logic [3:0] yv;
    int         ch;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'd0, 8'hA5, 1'b1, 4'hF, 4'b0001, 0};
    vecs[1] = '{2'd1, 8'hA5, 1'b1, 4'hF, 4'b0010, 1};
    vecs[2] = '{2'd2, 8'hA5, 1'b1, 4'hF, 4'b0100, 2};
    vecs[3] = '{2'd3, 8'hA5, 1'b1, 4'hF, 4'b1000, 3};
    vecs[4] = '{2'd2, 8'h11, 1'b0, 4'hF, 4'b0100, 2};
    vecs[5] = '{2'd0, 8'h22, 1'b0, 4'hF, 4'b0100, 2};
    vecs[6] = '{2'd0, 8'h33, 1'b1, 4'hF, 4'b0100, 2};
    vecs[7] = '{2'd0, 8'h44, 1'b1, 4'hF, 4'b0001, 0};

    rst = 1'b1;
    din = 8'h00; din_valid = 1'b0; din_last = 1'b0; a = 2'd0; y_ready = 4'hF;
    din3 = 8'h00; v3 = 1'b0; last3 = 1'b0; a3 = 2'd0; yr3 = 3'b111;
    clear_model();
    #12;
    check("reset y_valid", 64'(y_valid), 64'h0);
    check("reset err", 64'(err), 64'h0);
    check("reset Y", 64'(y), 64'h0);
    check("reset y_last", 64'(y_last), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Channel sweep and packet lock
    foreach (vecs[k]) begin
      a = vecs[k].a; din = vecs[k].d; din_last = vecs[k].last;
      y_ready = vecs[k].rdy; din_valid = 1'b1;
      cyc();
      check($sformatf("tbl%0d y_valid", k), 64'(y_valid), 64'(vecs[k].yv));
      check($sformatf("tbl%0d data", k), 64'(y[vecs[k].ch*8 +: 8]), 64'(vecs[k].d));
    end
    din_valid = 1'b0;
    cyc();
    cyc();

    // Backpressure on ch1 blocks only beats aimed at ch1
    y_ready = 4'b1101;
    a = 2'd1; din = 8'h55; din_last = 1'b1; din_valid = 1'b1;
    cyc();
    din = 8'h66;
    #1 check("bp ready to ch1", 64'(din_ready), 64'h0);
    a = 2'd3;
    #1 check("bp ready to ch3", 64'(din_ready), 64'h1);
    din = 8'h77;
    cyc();
    check("bp ch1 held ch3 loaded", 64'(y_valid), 64'b1010);
    a = 2'd1; din = 8'h66; y_ready = 4'hF;
    cyc();
    check("bp drain+load y_valid", 64'(y_valid), 64'b0010);
    check("bp drain+load data", 64'(y[15:8]), 64'h66);
    din_valid = 1'b0;
    cyc();

    // Asynchronous reset mid-packet
    a = 2'd0; din = 8'h10; din_last = 1'b0; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0; y_ready = 4'h0;
    rst = 1'b1;
    #1;
    check("async rst y_valid", 64'(y_valid), 64'h0);
    check("async rst err", 64'(err), 64'h0);
    clear_model();
    #2 rst = 1'b0;
    y_ready = 4'hF;
    a = 2'd3; din = 8'h99; din_last = 1'b1; din_valid = 1'b1;
    cyc();
    check("post rst routes by A", 64'(y_valid), 64'b1000);
    din_valid = 1'b0;
    cyc();

    // Out-of-range select on the 3-channel instance
    a3 = 2'd3; din3 = 8'h77; last3 = 1'b1; v3 = 1'b1;
    #1 check("oor ready", 64'(rdy3), 64'h1);
    @(posedge clk); #1;
    v3 = 1'b0;
    check("oor no y_valid", 64'(yv3), 64'h0);
    check("oor err pulse", 64'(err3), 64'h1);
    @(posedge clk); #1;
    check("oor err one cycle", 64'(err3), 64'h0);
    a3 = 2'd3; din3 = 8'h01; last3 = 1'b0; v3 = 1'b1;
    @(posedge clk); #1;
    check("oor pkt err beat1", 64'(err3), 64'h1);
    a3 = 2'd0; din3 = 8'h02; last3 = 1'b1;
    #1 check("oor pkt locked ready", 64'(rdy3), 64'h1);
    @(posedge clk); #1;
    v3 = 1'b0;
    check("oor pkt err beat2", 64'(err3), 64'h1);
    check("oor pkt no y_valid", 64'(yv3), 64'h0);
    @(posedge clk); #1;
    check("oor pkt err clear", 64'(err3), 64'h0);
    a3 = 2'd0; din3 = 8'h05; last3 = 1'b1; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    check("after oor pkt y_valid", 64'(yv3), 64'b001);
    check("after oor pkt data", 64'(y3[7:0]), 64'h05);
`ifdef DEMUX1N_STATS_EN
    check("drop_cnt3", 64'(drop_cnt3), 64'd3);
    check("drop_cnt4", 64'(drop_cnt4), 64'd0);

    // Beat counter on ch0
    rst = 1'b1;
    #1 clear_model();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    y_ready = 4'hF; a = 2'd0; din_last = 1'b1; din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 8'(8'h30 + k);
      cyc();
    end
    din_valid = 1'b0;
    cyc();
    cyc();
    check("beat_cnt ch0", 64'(beat_cnt4[15:0]), 64'd5);
    check("beat_cnt ch1", 64'(beat_cnt4[31:16]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
